// File: rtl/ps2_receiver.sv
// PS/2 device-to-host frame receiver: start bit, 8 data bits LSB first, odd parity, stop bit.
// Optional build macro PS2_RX_SYNC_EN adds two-flop synchronizers on psclk/psdata (+2 cycles latency).
module ps2_receiver #(
    parameter int TIMEOUT_CYCLES = 2000
) (
    input  logic       slowClk,
    input  logic       reset,
    input  logic       psclk,
    input  logic       psdata,
    input  logic       inhibit,
    output logic [7:0] rxByte,
    output logic       rxValid,
    output logic       parityErr,
    output logic       frameErr,
    output logic       busy
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Odd parity across 8 data bits plus the parity bit must XOR to 1.
    function automatic logic parityOk(input logic [8:0] bits);
        return ^bits;
    endfunction

    logic clkSmp;
    logic dataSmp;
    logic pastClk;
    logic fallEdge;

`ifdef PS2_RX_SYNC_EN
    logic [1:0] clkSync;
    logic [1:0] dataSync;

    always_ff @(posedge slowClk or posedge reset) begin
        if (reset) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[0], psclk};
            dataSync <= {dataSync[0], psdata};
        end
    end

    assign clkSmp  = clkSync[1];
    assign dataSmp = dataSync[1];
`else
    assign clkSmp  = psclk;
    assign dataSmp = psdata;
`endif

    // pastClk keeps tracking during inhibit so its release never looks like an edge.
    always_ff @(posedge slowClk or posedge reset) begin
        if (reset) begin
            pastClk <= 1'b1;
        end else begin
            pastClk <= clkSmp;
        end
    end

    assign fallEdge = pastClk & ~clkSmp;

    state_t          state;
    state_t          stateNext;
    logic [3:0]      bitCnt;
    logic [3:0]      bitCntNext;
    logic [9:0]      shreg;
    logic [9:0]      shregNext;
    logic [TO_W-1:0] toCnt;
    logic [TO_W-1:0] toCntNext;
    logic [7:0]      rxByteReg;
    logic            loadByte;

    always_ff @(posedge slowClk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bitCnt    <= '0;
            shreg     <= '0;
            toCnt     <= '0;
            rxByteReg <= '0;
        end else begin
            state  <= stateNext;
            bitCnt <= bitCntNext;
            shreg  <= shregNext;
            toCnt  <= toCntNext;
            if (loadByte) begin
                rxByteReg <= shreg[7:0];
            end
        end
    end

    // Bits shift in at the top, so after ten edges: [7:0] data, [8] parity, [9] stop.
    always_comb begin
        stateNext  = state;
        bitCntNext = bitCnt;
        shregNext  = shreg;
        toCntNext  = toCnt;
        rxValid    = 1'b0;
        parityErr  = 1'b0;
        frameErr   = 1'b0;
        loadByte   = 1'b0;

        case (state)
            IDLE: begin
                bitCntNext = '0;
                toCntNext  = '0;
                if (fallEdge && !dataSmp) begin
                    stateNext = SHIFT;
                end
            end
            SHIFT: begin
                if (fallEdge) begin
                    shregNext = {dataSmp, shreg[9:1]};
                    toCntNext = '0;
                    if (bitCnt == 4'd9) begin
                        stateNext = CHECK;
                    end else begin
                        bitCntNext = bitCnt + 4'd1;
                    end
                end else if (toCnt == TO_LAST) begin
                    frameErr  = 1'b1;
                    stateNext = IDLE;
                end else begin
                    toCntNext = toCnt + TO_W'(1);
                end
            end
            CHECK: begin
                stateNext  = IDLE;
                bitCntNext = '0;
                toCntNext  = '0;
                if (!shreg[9]) begin
                    frameErr = 1'b1;
                end else if (parityOk(shreg[8:0])) begin
                    rxValid  = 1'b1;
                    loadByte = 1'b1;
                end else begin
                    parityErr = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // The host owning the bus beats everything, including a frame about to complete.
        if (inhibit) begin
            stateNext  = IDLE;
            bitCntNext = '0;
            toCntNext  = '0;
            rxValid    = 1'b0;
            parityErr  = 1'b0;
            frameErr   = 1'b0;
            loadByte   = 1'b0;
        end
    end

    // Show the new byte in the same cycle as its rxValid strobe.
    assign rxByte = rxValid ? shreg[7:0] : rxByteReg;
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: good/bad-parity/bad-stop frames, timeout abort,
// inhibit and mid-frame reset, with strobe counts gathered by a monitor.
module tb_ps2_receiver;

    localparam int TIMEOUT = 200;
    localparam int HALF    = 20;

    logic       slowClk;
    logic       reset;
    logic       psclk;
    logic       psdata;
    logic       inhibit;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       parityErr;
    logic       frameErr;
    logic       busy;

    int nTests = 0;
    int nFail  = 0;
    int vCnt   = 0;
    int pCnt   = 0;
    int fCnt   = 0;
    int ovCnt  = 0;

    ps2_receiver #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .slowClk   (slowClk),
        .reset     (reset),
        .psclk     (psclk),
        .psdata    (psdata),
        .inhibit   (inhibit),
        .rxByte    (rxByte),
        .rxValid   (rxValid),
        .parityErr (parityErr),
        .frameErr  (frameErr),
        .busy      (busy)
    );

    initial slowClk = 1'b0;
    always #5 slowClk = ~slowClk;

    always @(negedge slowClk) begin
        if (rxValid === 1'b1) vCnt++;
        if (parityErr === 1'b1) pCnt++;
        if (frameErr === 1'b1) fCnt++;
        if ((int'(rxValid) + int'(parityErr) + int'(frameErr)) > 1) ovCnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge slowClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] frm(input logic [7:0] d, input logic par, input logic stop);
        return {stop, par, d, 1'b0};
    endfunction

    // Drives nEdges bits; stb holds {rxValid,parityErr,frameErr} one cycle after the last falling edge.
    task automatic sendBits(input logic [10:0] bits, input int nEdges, output logic [2:0] stb);
        stb = 3'b000;
        for (int i = 0; i < nEdges; i++) begin
            psdata = bits[i];
            tick(HALF);
            psclk = 1'b0;
            tick(1);
            stb = {rxValid, parityErr, frameErr};
            tick(HALF - 1);
            psclk = 1'b1;
        end
        tick(HALF);
        psdata = 1'b1;
    endtask

    initial begin
        logic [2:0] stb;
        int v0, p0, f0, k;

        psclk   = 1'b1;
        psdata  = 1'b1;
        inhibit = 1'b0;
        reset   = 1'b1;
        tick(3);
        chk("rst_rxByte", rxByte, 8'h00);
        chk("rst_rxValid", rxValid, 1'b0);
        chk("rst_parityErr", parityErr, 1'b0);
        chk("rst_frameErr", frameErr, 1'b0);
        chk("rst_busy", busy, 1'b0);
        reset = 1'b0;
        tick(5);

        // Falling edge with data high while idle is not a start bit
        sendBits(11'h7FF, 1, stb);
        tick(5);
        chk("idle_one_busy", busy, 1'b0);
        chk("idle_one_strobes", vCnt + pCnt + fCnt, 0);

        // Good 0x1C, parity 0
        v0 = vCnt; p0 = pCnt; f0 = fCnt;
        sendBits(frm(8'h1C, 1'b0, 1'b1), 11, stb);
        chk("1c_latency_stb", stb, 3'b100);
        tick(5);
        chk("1c_valid_cnt", vCnt - v0, 1);
        chk("1c_err_cnt", (pCnt - p0) + (fCnt - f0), 0);
        chk("1c_rxByte", rxByte, 8'h1C);
        chk("1c_busy_after", busy, 1'b0);

        // 0xF0 with bad parity 0
        v0 = vCnt; p0 = pCnt; f0 = fCnt;
        sendBits(frm(8'hF0, 1'b0, 1'b1), 11, stb);
        chk("f0_stb", stb, 3'b010);
        tick(5);
        chk("f0_par_cnt", pCnt - p0, 1);
        chk("f0_other_cnt", (vCnt - v0) + (fCnt - f0), 0);
        chk("f0_rxByte_kept", rxByte, 8'h1C);

        // 0x5A good parity, bad stop, then a good 0x5A
        v0 = vCnt; p0 = pCnt; f0 = fCnt;
        sendBits(frm(8'h5A, 1'b1, 1'b0), 11, stb);
        chk("5a_stop_stb", stb, 3'b001);
        tick(5);
        chk("5a_frm_cnt", fCnt - f0, 1);
        chk("5a_other_cnt", (vCnt - v0) + (pCnt - p0), 0);
        chk("5a_rxByte_kept", rxByte, 8'h1C);
        sendBits(frm(8'h5A, 1'b1, 1'b1), 11, stb);
        chk("5a_good_stb", stb, 3'b100);
        tick(5);
        chk("5a_rxByte", rxByte, 8'h5A);

        // Five edges then psclk idles high until timeout
        v0 = vCnt; p0 = pCnt; f0 = fCnt;
        psdata = 1'b0;
        tick(HALF);
        for (int i = 0; i < 5; i++) begin
            psdata = frm(8'h29, 1'b0, 1'b1) >> i;
            tick(HALF);
            psclk = 1'b0;
            tick(HALF);
            psclk = 1'b1;
        end
        chk("to_busy_mid", busy, 1'b1);
        k = 0;
        while (fCnt == f0 && k < TIMEOUT + 50) begin
            tick(1);
            k++;
        end
        chk("to_seen_in_window", (k >= TIMEOUT - HALF - 10) && (k <= TIMEOUT - HALF + 10), 1'b1);
        tick(3);
        chk("to_frm_cnt", fCnt - f0, 1);
        chk("to_busy_after", busy, 1'b0);
        chk("to_other_cnt", (vCnt - v0) + (pCnt - p0), 0);
        psdata = 1'b1;
        sendBits(frm(8'h29, 1'b0, 1'b1), 11, stb);
        chk("29_stb", stb, 3'b100);
        tick(5);
        chk("29_rxByte", rxByte, 8'h29);

        // Inhibit after 4 data bits; bus activity while inhibited is discarded
        v0 = vCnt; p0 = pCnt; f0 = fCnt;
        sendBits(frm(8'h12, 1'b1, 1'b1), 5, stb);
        chk("inh_busy_before", busy, 1'b1);
        inhibit = 1'b1;
        tick(2);
        chk("inh_busy", busy, 1'b0);
        sendBits(frm(8'h34, 1'b0, 1'b1), 11, stb);
        chk("inh_stb", stb, 3'b000);
        inhibit = 1'b0;
        tick(5);
        chk("inh_no_strobes", (vCnt - v0) + (pCnt - p0) + (fCnt - f0), 0);
        chk("inh_rxByte_kept", rxByte, 8'h29);
        sendBits(frm(8'h12, 1'b1, 1'b1), 11, stb);
        chk("12_stb", stb, 3'b100);
        tick(5);
        chk("12_rxByte", rxByte, 8'h12);
        chk("12_valid_cnt", vCnt - v0, 1);

        // Reset in the middle of a frame
        v0 = vCnt; p0 = pCnt; f0 = fCnt;
        sendBits(frm(8'h77, 1'b1, 1'b1), 5, stb);
        reset = 1'b1;
        tick(2);
        chk("mrst_rxByte", rxByte, 8'h00);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_strobes", {rxValid, parityErr, frameErr}, 3'b000);
        reset = 1'b0;
        tick(5);
        chk("mrst_no_strobes", (vCnt - v0) + (pCnt - p0) + (fCnt - f0), 0);
        sendBits(frm(8'hA5, 1'b1, 1'b1), 11, stb);
        chk("a5_stb", stb, 3'b100);
        tick(5);
        chk("a5_rxByte", rxByte, 8'hA5);
        chk("no_overlap", ovCnt, 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
